// File: rtl/regbank_dump.sv
// Register-bank dump engine: reads every register and streams it MSB byte first
// over a valid/ready byte interface. Define REGBANK_DUMP_HEADER_EN to prefix the stream with 8'hA5.
module regbank_dump #(
  parameter int bits_wide = 32,
  parameter int reg_count = 32,
  parameter int addr_bits = 5
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [addr_bits-1:0] rd_addr,
  output logic                 rd_enable,
  input  logic [bits_wide-1:0] rd_data,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready
);

  // state  | meaning
  // IDLE   | waiting for start
  // HEADER | presenting 8'hA5 marker (REGBANK_DUMP_HEADER_EN builds only)
  // READ   | rd_enable strobe for reg_index
  // WAIT   | bank registers rd_data; captured into shift_reg on exit
  // SEND   | streaming shift_reg bytes, MSB first
  // DONE   | one-cycle done pulse

  localparam int NBYTES = bits_wide / 8;
  localparam int BCW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [BCW-1:0]       LAST_BYTE = BCW'(NBYTES - 1);
  localparam logic [addr_bits-1:0] LAST_REG  = addr_bits'(reg_count - 1);
  localparam logic [7:0]           HDR_BYTE  = 8'hA5;

`ifdef REGBANK_DUMP_HEADER_EN
  typedef enum logic [2:0] {IDLE, READ, WAIT, SEND, DONE, HEADER} state_t;
  localparam state_t FIRST_STATE = HEADER;
`else
  typedef enum logic [2:0] {IDLE, READ, WAIT, SEND, DONE} state_t;
  localparam state_t FIRST_STATE = READ;
`endif

  state_t               state;
  state_t               state_nxt;
  logic [addr_bits-1:0] reg_index;
  logic [BCW-1:0]       byte_cnt;
  logic [bits_wide-1:0] shift_reg;
  logic                 last_byte;
  logic                 last_reg;

  assign last_byte = (byte_cnt == LAST_BYTE);
  assign last_reg  = (reg_index == LAST_REG);
  // Address holds the last index outside READ, so it is simply the index register.
  assign rd_addr   = reg_index;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    rd_enable = 1'b0;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_nxt = FIRST_STATE;
        end
      end
`ifdef REGBANK_DUMP_HEADER_EN
      HEADER: begin
        tx_valid = 1'b1;
        tx_data  = HDR_BYTE;
        if (tx_ready) begin
          state_nxt = READ;
        end
      end
`endif
      READ: begin
        rd_enable = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        state_nxt = SEND;
      end
      SEND: begin
        tx_valid = 1'b1;
        tx_data  = shift_reg[bits_wide-1 -: 8];
        if (tx_ready && last_byte) begin
          state_nxt = last_reg ? DONE : READ;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      reg_index <= '0;
      byte_cnt  <= '0;
      shift_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            reg_index <= '0;
          end
        end
        WAIT: begin
          shift_reg <= rd_data;
          byte_cnt  <= '0;
        end
        SEND: begin
          if (tx_ready) begin
            shift_reg <= shift_reg << 8;
            byte_cnt  <= byte_cnt + BCW'(1);
            // Index stays on the final register after the dump so rd_addr keeps it.
            if (last_byte && !last_reg) begin
              reg_index <= reg_index + addr_bits'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regbank_dump.sv
// Directed bench for regbank_dump: full dumps under steady, toggling and random
// tx_ready, start held high, and reset mid-dump.
module tb_regbank_dump;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        busy;
  logic        done;
  logic [4:0]  rd_addr;
  logic        rd_enable;
  logic [31:0] rd_data = 32'h0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;

  regbank_dump #(.bits_wide(32), .reg_count(32), .addr_bits(5)) dut (
    .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
    .rd_addr(rd_addr), .rd_enable(rd_enable), .rd_data(rd_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  always #5 clock = ~clock;

  logic [31:0] mem [32];
  always @(posedge clock) begin
    if (rd_enable) rd_data <= mem[rd_addr];
  end

  int ready_mode = 0;
  always @(posedge clock) begin
    #1;
    case (ready_mode)
      0: tx_ready = 1'b1;
      1: tx_ready = ~tx_ready;
      default: tx_ready = ($urandom_range(0, 2) != 0);
    endcase
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  logic [7:0] bytes_q [$];
  logic [4:0] addrs_q [$];
  logic [7:0] exp_q   [$];
  int cyc = 0, busy_cnt = 0, done_cnt = 0, overlap = 0, stab_err = 0;
  int last_tx_cyc = 0, done_cyc = 0;
  logic       hold_pend = 1'b0;
  logic [7:0] hold_byte = 8'h00;

  always @(negedge clock) begin
    cyc++;
    if (reset) begin
      if (tx_valid && tx_ready) begin
        bytes_q.push_back(tx_data);
        last_tx_cyc = cyc;
      end
      if (rd_enable) addrs_q.push_back(rd_addr);
      if (rd_enable && tx_valid) overlap++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (busy) busy_cnt++;
      if (hold_pend && !(tx_valid && tx_data == hold_byte)) stab_err++;
      hold_pend = tx_valid && !tx_ready;
      hold_byte = tx_data;
    end else begin
      hold_pend = 1'b0;
    end
  end

  task automatic clear_log();
    bytes_q.delete();
    addrs_q.delete();
    busy_cnt = 0;
    done_cnt = 0;
    overlap  = 0;
    stab_err = 0;
  endtask

  task automatic build_expected();
    exp_q.delete();
`ifdef REGBANK_DUMP_HEADER_EN
    exp_q.push_back(8'hA5);
`endif
    for (int k = 0; k < 32; k++) begin
      for (int b = 3; b >= 0; b--) exp_q.push_back(mem[k][8*b +: 8]);
    end
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clock);
      n++;
    end
    check("done_timeout", {63'd0, (n >= budget)}, 64'd0);
  endtask

  task automatic pulse_start();
    @(posedge clock); #1;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  // Called at the negedge after the done cycle so the monitor has settled.
  task automatic check_dump(input string tag, input int exp_busy);
    int bad_addr = 0;
    check({tag, "_nbytes"}, bytes_q.size(), exp_q.size());
    for (int i = 0; i < bytes_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), bytes_q[i], exp_q[i]);
    check({tag, "_nreads"}, addrs_q.size(), 32);
    for (int i = 0; i < addrs_q.size(); i++)
      if (addrs_q[i] != 5'(i)) bad_addr++;
    check({tag, "_addr_order"}, bad_addr, 0);
    check({tag, "_overlap"}, overlap, 0);
    check({tag, "_stable"}, stab_err, 0);
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_done_lat"}, done_cyc - last_tx_cyc, 1);
    if (exp_busy > 0) check({tag, "_busy_cycles"}, busy_cnt, exp_busy);
  endtask

  int hdr_extra;

  initial begin
`ifdef REGBANK_DUMP_HEADER_EN
    hdr_extra = 1;
`else
    hdr_extra = 0;
`endif
    for (int k = 0; k < 32; k++) mem[k] = 32'h01020300 + 32'(k);

    // reset state
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_enable", rd_enable, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    reset = 1'b1;
    repeat (2) @(posedge clock);

    // steady ready
    #1;
    build_expected();
    clear_log();
    pulse_start();
    wait_done(2000);
    @(negedge clock);
    check("steady_busy_after", busy, 0);
    check_dump("steady", 193 + hdr_extra);

    // ready toggling, reg 5 = DEADBEEF
    mem[5] = 32'hDEADBEEF;
    build_expected();
    @(posedge clock); #1;
    ready_mode = 1;
    clear_log();
    pulse_start();
    wait_done(4000);
    @(negedge clock);
    check_dump("toggle", 0);
    check("toggle_reg5_b0", bytes_q.size() > 20 + hdr_extra ? bytes_q[20 + hdr_extra] : 8'h00, 8'hDE);
    check("toggle_reg5_b3", bytes_q.size() > 23 + hdr_extra ? bytes_q[23 + hdr_extra] : 8'h00, 8'hEF);

    // random ready stalls
    @(posedge clock); #1;
    ready_mode = 2;
    clear_log();
    pulse_start();
    wait_done(6000);
    @(negedge clock);
    check_dump("random", 0);

    // start held high through the dump
    @(posedge clock); #1;
    ready_mode = 0;
    clear_log();
    start = 1'b1;
    wait_done(2000);
    @(negedge clock);
    check("held_idle_busy", busy, 0);
    check("held_one_done", done_cnt, 1);
    check("held_nbytes", bytes_q.size(), exp_q.size());
    @(negedge clock);
    check("held_restart_busy", busy, 1);
    check("held_restart_rd_enable", rd_enable, 1);
    check("held_restart_rd_addr", rd_addr, 0);
    @(posedge clock); #1;
    start = 1'b0;
    wait_done(2000);
    @(negedge clock);
    check("held_second_done", done_cnt, 2);

    // reset while second byte of reg 10 is presented
    mem[10] = 32'h0102030A;
    build_expected();
    @(posedge clock); #1;
    clear_log();
    pulse_start();
    begin
      int n = 0;
      while (!(tx_valid && rd_addr == 5'd10 && tx_data == 8'h02) && n < 2000) begin
        @(negedge clock);
        n++;
      end
      check("rstmid_reach_timeout", {63'd0, (n >= 2000)}, 64'd0);
    end
    reset = 1'b0;
    @(posedge clock); #1;
    check("rstmid_busy", busy, 0);
    check("rstmid_tx_valid", tx_valid, 0);
    check("rstmid_tx_data", tx_data, 0);
    check("rstmid_rd_enable", rd_enable, 0);
    check("rstmid_rd_addr", rd_addr, 0);
    check("rstmid_done", done, 0);
    reset = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    check("rstmid_no_done", done_cnt, 0);
    check("rstmid_idle", busy, 0);
    clear_log();
    pulse_start();
    wait_done(2000);
    @(negedge clock);
    check_dump("after_rst", 193 + hdr_extra);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
